// File: rtl/alu_exec_unit.sv
// Request-side sequencer for the 8-bit ALU: register file, operand staging, result select, writeback.
// Optional EXEC_ZERO_FLAG_EN adds a registered zero_flag output updated on each writeback.
module alu_exec_unit #(
  parameter int          NREGS     = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         AW        = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_out0,
  input  logic [7:0]    alu_out1,
  input  logic [7:0]    alu_out2,
  input  logic [7:0]    alu_out3,
  input  logic [7:0]    alu_out4,
  input  logic [7:0]    alu_out5,
  input  logic [7:0]    alu_out6,
  input  logic [7:0]    alu_out7,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [7:0]    wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
`ifdef EXEC_ZERO_FLAG_EN
  output logic          zero_flag,
`endif
  input  logic [AW-1:0] rd_sel,
  output logic [7:0]    rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          req_ready_r, wb_valid_r, accept_s;
  logic [2:0]    op_r;
  logic [AW-1:0] rd_r;
  logic [7:0]    op_a_r, op_b_r, res_r, res_s;
  logic [7:0]    regs_r [NREGS];

  assign accept_s  = (state_r == ST_IDLE) && req_valid;
  assign req_ready = req_ready_r;
  assign wb_valid  = wb_valid_r;
  assign wb_rd     = rd_r;
  assign wb_data   = res_r;
  assign alu_a     = op_a_r;
  assign alu_b     = op_b_r;
  assign rd_data   = regs_r[rd_sel];

  // Next-state decode for the IDLE -> EXEC -> WB sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_s = ST_EXEC;
        else           state_s = ST_IDLE;
      end
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Result-bus select by latched opcode.
  always_comb begin
    res_s = 8'h00;
    case (op_r)
      3'd0:    res_s = alu_out0;
      3'd1:    res_s = alu_out1;
      3'd2:    res_s = alu_out2;
      3'd3:    res_s = alu_out3;
      3'd4:    res_s = alu_out4;
      3'd5:    res_s = alu_out5;
      3'd6:    res_s = alu_out6;
      3'd7:    res_s = alu_out7;
      default: res_s = 8'h00;
    endcase
  end

  // State, handshake outputs and operand/result staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      wb_valid_r  <= 1'b0;
      op_r        <= 3'd0;
      rd_r        <= '0;
      op_a_r      <= 8'h00;
      op_b_r      <= 8'h00;
      res_r       <= 8'h00;
    end else begin
      state_r     <= state_s;
      // Handshake flags follow the next state so they stay glitch-free flop outputs.
      req_ready_r <= (state_s == ST_IDLE);
      wb_valid_r  <= (state_s == ST_WB);
      if (accept_s) begin
        op_r   <= req_op;
        rd_r   <= req_rd;
        op_a_r <= regs_r[req_rs1];
        op_b_r <= regs_r[req_rs2];
      end
      if (state_r == ST_EXEC) res_r <= res_s;
    end
  end

  // Register file: external load first, writeback last so it wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= RESET_VAL;
    end else begin
      if (ld_en) regs_r[ld_addr] <= ld_data;
      if (state_r == ST_WB) regs_r[rd_r] <= res_r;
    end
  end

`ifdef EXEC_ZERO_FLAG_EN
  logic zero_flag_r;
  assign zero_flag = zero_flag_r;

  // Zero flag tracks the most recent writeback only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 zero_flag_r <= 1'b0;
    else if (state_r == ST_WB)  zero_flag_r <= (res_r == 8'h00);
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit with a behavioural ALU stand-in on the result buses.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [2:0] req_op = 3'd0;
  logic [1:0] req_rd = 2'd0, req_rs1 = 2'd0, req_rs2 = 2'd0;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out0, alu_out1, alu_out2, alu_out3, alu_out4, alu_out5, alu_out6, alu_out7;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = 2'd0;
  logic [7:0] ld_data = 8'h00;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] rd_data;
`ifdef EXEC_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct { logic [1:0] rd; logic [7:0] data; int cyc; } exp_t;
  exp_t exp_q[$];

  alu_exec_unit #(.NREGS(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_out3(alu_out3),
    .alu_out4(alu_out4), .alu_out5(alu_out5), .alu_out6(alu_out6), .alu_out7(alu_out7),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef EXEC_ZERO_FLAG_EN
    .zero_flag(zero_flag),
`endif
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: shifts are by one, compare yields 0xFF on equality.
  always_comb begin
    alu_out0 = alu_a + alu_b;
    alu_out1 = alu_a << 1;
    alu_out2 = alu_a >> 1;
    alu_out3 = alu_a & alu_b;
    alu_out4 = alu_a | alu_b;
    alu_out5 = alu_a ^ alu_b;
    alu_out6 = ~(alu_a & alu_b);
    alu_out7 = (alu_a == alu_b) ? 8'hFF : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {30'd0, wb_rd}, {30'd0, e.rd});
        chk("wb_data", {24'd0, wb_data}, {24'd0, e.data});
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] d);
    rd_sel = a;
    #1;
    chk(name, {24'd0, rd_data}, {24'd0, d});
  endtask

  // Presents a request at a negedge; returns at the negedge after the accept edge (EXEC).
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] d, input bit push,
                      output int acc);
    int t;
    exp_t e;
    t = 0;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    while (!req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
    acc = cyc;
    if (push) begin
      e.rd = rd; e.data = d; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc, prev;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    chk("rst_wb_rd_data", {22'd0, wb_rd, wb_data}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk("rst_regfile", 2'(i), 8'h00);
`ifdef EXEC_ZERO_FLAG_EN
    chk("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
`endif

    // Add with wrap: 0x0F + 0xF3 = 0x02
    load(2'd1, 8'h0F);
    load(2'd2, 8'hF3);
    send(3'd0, 2'd3, 2'd1, 2'd2, 8'h02, 1'b1, acc);
    chk("exec_alu_a", {24'd0, alu_a}, 32'h0F);
    chk("exec_alu_b", {24'd0, alu_b}, 32'hF3);
    chk("exec_ready_low", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wb_ready_low", {31'd0, req_ready}, 32'd0);
    drain();
    rd_chk("add_rd3", 2'd3, 8'h02);
`ifdef EXEC_ZERO_FLAG_EN
    chk("add_zero_flag", {31'd0, zero_flag}, 32'd0);
`endif

    // Compare with itself, then xor with itself
    load(2'd0, 8'h05);
    send(3'd7, 2'd1, 2'd0, 2'd0, 8'hFF, 1'b1, acc);
    drain();
    send(3'd5, 2'd2, 2'd0, 2'd0, 8'h00, 1'b1, acc);
    drain();
`ifdef EXEC_ZERO_FLAG_EN
    chk("xor_zero_flag", {31'd0, zero_flag}, 32'd1);
`endif
    rd_chk("cmp_rd1", 2'd1, 8'hFF);
    // regs: r0=05 r1=FF r2=00 r3=02

    // Back-pressure: valid held high, each request depends on the previous writeback
    send(3'd1, 2'd0, 2'd1, 2'd1, 8'hFE, 1'b1, prev);
    send(3'd4, 2'd2, 2'd3, 2'd0, 8'hFE, 1'b1, acc);
    chk("bp_spacing1", acc - prev, 32'd3); prev = acc;
    send(3'd6, 2'd3, 2'd2, 2'd3, 8'hFD, 1'b1, acc);
    chk("bp_spacing2", acc - prev, 32'd3); prev = acc;
    send(3'd2, 2'd1, 2'd3, 2'd3, 8'h7E, 1'b1, acc);
    chk("bp_spacing3", acc - prev, 32'd3); prev = acc;
    send(3'd3, 2'd0, 2'd1, 2'd3, 8'h7C, 1'b1, acc);
    chk("bp_spacing4", acc - prev, 32'd3);
    drain();
    rd_chk("bp_r0", 2'd0, 8'h7C);
    rd_chk("bp_r1", 2'd1, 8'h7E);
    rd_chk("bp_r2", 2'd2, 8'hFE);
    rd_chk("bp_r3", 2'd3, 8'hFD);

    // Load and writeback to the same register on the WB edge: writeback wins
    load(2'd0, 8'h11);
    send(3'd3, 2'd1, 2'd0, 2'd0, 8'h11, 1'b1, acc);
    req_valid = 1'b0;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
    @(negedge clk);
    ld_en = 1'b0;
    drain();
    rd_chk("collide_wb_wins", 2'd1, 8'h11);

    // Load to rs on the accept edge: operand uses old value 0xFE
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h00;
    send(3'd4, 2'd3, 2'd2, 2'd2, 8'hFE, 1'b1, acc);
    ld_en = 1'b0;
    chk("ld_rs_old_a", {24'd0, alu_a}, 32'hFE);
    drain();
    rd_chk("ld_rs_r2", 2'd2, 8'h00);
    rd_chk("ld_rs_r3", 2'd3, 8'hFE);

    // Reset during EXEC: no writeback, regfile cleared
    send(3'd0, 2'd0, 2'd1, 2'd1, 8'h00, 1'b0, acc);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) rd_chk("midrst_regfile", 2'(i), 8'h00);
`ifdef EXEC_ZERO_FLAG_EN
    chk("midrst_zero_flag", {31'd0, zero_flag}, 32'd0);
`endif
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequencing wrapper on the request side of the 8-bit ALU. It accepts operation requests from the control path and reads two operands from a small internal register file. It drives the ALU's A/B inputs, selects one of the eight parallel ALU result buses by opcode, and writes the result back to the register file with a writeback strobe. It sits between the instruction decoder and the ALU in the tiny CPU datapath.

## Interface
Parameters:
- NREGS, 4: register-file depth; power of two; address width AW = log2(NREGS).
- RESET_VAL, 8'h00: reset value of every register-file entry.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  result select: 0 add, 1 shl, 2 shr, 3 and, 4 or, 5 xor, 6 nand, 7 compare.
- req_rd, req_rs1, req_rs2  in  AW  destination and source register indices.
- alu_a, alu_b  out  8  operands to the ALU.
- alu_out0 … alu_out7  in  8 each  ALU result buses, index = opcode.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  AW  writeback register index.
- wb_data  out  8  writeback data.
- ld_en, ld_addr (AW), ld_data (8)  in  external register load port.
- rd_sel  in  AW; rd_data  out  8  combinational register read (debug/store path).

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready at an edge, latch op and rd. Latch regfile[rs1] into op_a and regfile[rs2] into op_b using pre-edge values. Go to EXEC.
- EXEC: alu_a=op_a, alu_b=op_b (registered, glitch-free). At the edge, capture res = alu_out[op] and go to WB.
- WB: wb_valid=1, wb_rd=rd, wb_data=res. At the edge, write regfile[rd]=res and go to IDLE.
- req_ready=0 in EXEC and WB. Requests presented then are not accepted and must be held by the requester.
- ld_en writes regfile[ld_addr]=ld_data at the edge, in any state.
- When ld_en and the WB write target the same address at the same edge, the WB write wins.
- ld_en to an rs register at the accept edge: the operand takes the old value.
- rs1==rs2 is legal. rd may equal rs1 or rs2.
- All data is 8-bit with no carry-out. Add wraps mod 256. Opcode semantics are owned by the ALU; this unit only selects the bus.
- rd_data = regfile[rd_sel], combinational, and reflects writes after the writing edge.

## Timing
- Reset values: req_ready=1, alu_a=alu_b=0, wb_valid=0, wb_rd=0, wb_data=0, every regfile entry = RESET_VAL.
- Latency, accept edge E0 as reference: EXEC during cycle E0..E1, result captured at E1, wb_valid high during cycle E1..E2, register written at E2.
- req_ready returns high after E2. The earliest next accept is E3, and it sees the E2 write.
- Throughput: one operation per 3 cycles.
- wb_valid is high for exactly one cycle per accepted request.
- Reset asserted mid-operation: immediate return to IDLE, the pending operation is dropped, no wb_valid is produced, and the regfile is cleared.

## Configuration
- EXEC_ZERO_FLAG_EN defined: adds output port zero_flag (1 bit).
  - Registered, reset 0.
  - Updated at the WB edge to (res==8'h00).
  - Unchanged by ld_en and held between operations.
- EXEC_ZERO_FLAG_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: rst_n low, then released, with no requests -> req_ready=1, wb_valid=0, rd_data=0x00 for every rd_sel.
- Add with wrap: ld r1=0x0F and r2=0xF3, then req op=0, rd=3, rs1=1, rs2=2 -> alu_a=0x0F and alu_b=0xF3 in EXEC; wb_valid pulse with wb_rd=3, wb_data=0x02 two cycles after accept; rd_data(3)=0x02; zero_flag=0 if enabled.
- Compare and zero: r0=0x05 and rs1=rs2=0 with op=7 -> wb_data=0xFF. Then op=5 (xor) with rs1=rs2=0 -> wb_data=0x00 and zero_flag=1 if enabled.
- Back-pressure: hold req_valid high continuously with distinct ops -> accepts occur exactly every 3 cycles; req_ready low in EXEC and WB; no request is lost or duplicated.
- Collision: ld_en to the same address as the WB write at the WB edge, ld_data=0xAA, res=0x11 -> register holds 0x11. ld_en to rs1 at the accept edge -> the operand is the old value.
- Reset mid-op: assert rst_n low during EXEC -> no wb_valid, registers read RESET_VAL, req_ready=1 after release.
